// File: rtl/window_fetch_avalon.sv
// 3x3 neighbourhood fetcher: reads the window around (row_i, col_i) over an
// Avalon-MM read master, zero-pads off-image taps and hands the window downstream.
module window_fetch_avalon #(
   parameter int                    IMG_W      = 64,
   parameter int                    IMG_H      = 64,
   parameter int                    ROW_WIDTH  = 6,
   parameter int                    COL_WIDTH  = 6,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    WORD_BYTES = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [ROW_WIDTH-1:0]    row_i,
   input  logic [COL_WIDTH-1:0]    col_i,
   output logic                    busy_o,
   output logic                    win_valid_o,
   input  logic                    win_ready_i,
   output logic [9*DATA_WIDTH-1:0] win_o,
   output logic [ADDR_WIDTH-1:0]   avm_address_o,
   output logic                    avm_read_o,
   input  logic                    avm_waitrequest_i,
   input  logic [31:0]             avm_readdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_t;

   state_t                 state;
   logic [3:0]             k;
   logic [ROW_WIDTH-1:0]   row_q;
   logic [COL_WIDTH-1:0]   col_q;
   logic [9*DATA_WIDTH-1:0] win_q;

   logic signed [1:0]         dr, dc;
   logic signed [ROW_WIDTH:0] r;
   logic signed [COL_WIDTH:0] c;
   logic                      in_img;
   logic                      rd_en;
   logic [ADDR_WIDTH-1:0]     pix_idx;
   logic [ADDR_WIDTH-1:0]     tap_addr;

   // Tap k walks the window row-major: k = 3*(dr+1) + (dc+1).
   always_comb begin
      dr = 2'sd1;
      dc = 2'sd1;
      case (k)
         4'd0, 4'd1, 4'd2: dr = -2'sd1;
         4'd3, 4'd4, 4'd5: dr = 2'sd0;
         default:          dr = 2'sd1;
      endcase
      case (k)
         4'd0, 4'd3, 4'd6: dc = -2'sd1;
         4'd1, 4'd4, 4'd7: dc = 2'sd0;
         default:          dc = 2'sd1;
      endcase
   end

   // One guard bit is enough: any wrap lands on a negative value, which is off-image anyway.
   assign r = $signed({1'b0, row_q}) + (ROW_WIDTH+1)'(dr);
   assign c = $signed({1'b0, col_q}) + (COL_WIDTH+1)'(dc);

   assign in_img = (r >= 0) && (r < IMG_H) && (c >= 0) && (c < IMG_W);
   assign rd_en  = (state == FETCH) && in_img;

   assign pix_idx  = ADDR_WIDTH'($unsigned(r)) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'($unsigned(c));
   assign tap_addr = BASE_ADDR + pix_idx * ADDR_WIDTH'(WORD_BYTES);

   // NOTE: the bus side is combinational from registered state, so an async
   // reset of the state register drops avm_read_o without waiting for a clock.
   assign avm_read_o    = rd_en;
   assign avm_address_o = rd_en ? tap_addr : '0;

   assign busy_o      = (state != IDLE);
   assign win_valid_o = (state == HOLD);
   assign win_o       = win_q;

   // NOTE: sequential state uses non-blocking assignments only; the window
   // register is reset too so a discarded partial window never leaks out.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         k     <= '0;
         row_q <= '0;
         col_q <= '0;
         win_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  row_q <= row_i;
                  col_q <= col_i;
                  k     <= '0;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (!in_img || !avm_waitrequest_i) begin
                  win_q[int'(k)*DATA_WIDTH +: DATA_WIDTH] <=
                     in_img ? avm_readdata_i[DATA_WIDTH-1:0] : '0;
                  if (k == 4'd8) begin
                     k     <= '0;
                     state <= HOLD;
                  end else begin
                     k <= k + 4'd1;
                  end
               end
            end
            HOLD: begin
               if (win_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   generate
      if (DATA_WIDTH < 32) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^avm_readdata_i[31:DATA_WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_window_fetch_avalon.sv
// Directed bench for window_fetch_avalon: an Avalon slave model with a stall
// injector, a pixel pattern and a window model built from the image geometry.
module tb_window_fetch_avalon;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  row_in;
   logic [5:0]  col_in;
   logic        busy;
   logic        win_valid;
   logic        win_ready;
   logic [71:0] win;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        waitreq;
   logic [31:0] avm_readdata;

   int n_pass  = 0;
   int n_total = 0;

   // Slave model state
   int   rd_log[$];
   int   stall_addr_log[$];
   logic stall_read_log[$];
   int   stall_addr;
   int   stall_left;
   logic stalling;

   always #5 clk = ~clk;

   window_fetch_avalon dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_i           (start),
      .row_i             (row_in),
      .col_i             (col_in),
      .busy_o            (busy),
      .win_valid_o       (win_valid),
      .win_ready_i       (win_ready),
      .win_o             (win),
      .avm_address_o     (avm_address),
      .avm_read_o        (avm_read),
      .avm_waitrequest_i (waitreq),
      .avm_readdata_i    (avm_readdata)
   );

   function automatic logic [7:0] pix(input int idx);
      return 8'((idx * 37 + 11) & 255);
   endfunction

   function automatic logic [71:0] exp_win(input int row, input int col);
      logic [71:0] w;
      w = '0;
      for (int t = 0; t < 9; t++) begin
         int rr, cc;
         rr = row + t / 3 - 1;
         cc = col + t % 3 - 1;
         if (rr >= 0 && rr < 64 && cc >= 0 && cc < 64) w[t*8 +: 8] = pix(rr * 64 + cc);
      end
      return w;
   endfunction

   // Upper bits carry junk; low byte is junk while stalled.
   assign avm_readdata = {24'hC35A96, waitreq ? 8'hEE : pix(int'(avm_address >> 2))};

   // Waitrequest is decided at the negedge so it covers the following rising edge.
   always @(negedge clk) begin
      if (stall_left > 0 && (stalling || (avm_read && int'(avm_address) == stall_addr))) begin
         waitreq = 1'b1;
         stalling = 1'b1;
         stall_left--;
         stall_addr_log.push_back(int'(avm_address));
         stall_read_log.push_back(avm_read);
      end else begin
         waitreq = 1'b0;
         stalling = 1'b0;
      end
      if (avm_read && !waitreq) rd_log.push_back(int'(avm_address >> 2));
   end

   task automatic do_fetch(input int row, input int col, output int cycles);
      rd_log.delete();
      row_in = 6'(row);
      col_in = 6'(col);
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 1;
      while (!win_valid && cycles < 60) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic handshake();
      win_ready = 1'b1;
      @(posedge clk); #1;
      win_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({busy, win_valid, avm_read} !== 3'b000) $display("FAIL reset_ctl got %b exp 000", {busy, win_valid, avm_read});
      else n_pass++;
      n_total++;
      if (avm_address !== 32'd0) $display("FAIL reset_addr got %0h exp 0", avm_address);
      else n_pass++;
      n_total++;
      if (win !== 72'd0) $display("FAIL reset_win got %h exp 0", win);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_interior();
      int cyc, n;
      do_fetch(5, 7, cyc);
      n_total++;
      if (cyc !== 10) $display("FAIL int_latency got %0d exp 10", cyc);
      else n_pass++;
      n_total++;
      if (rd_log.size() !== 9) $display("FAIL int_nreads got %0d exp 9", rd_log.size());
      else n_pass++;
      n = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            n_total++;
            if (n < rd_log.size() && rd_log[n] == (4 + i) * 64 + 6 + j) n_pass++;
            else $display("FAIL int_read%0d got %0d exp %0d", n, (n < rd_log.size()) ? rd_log[n] : -1, (4 + i) * 64 + 6 + j);
            n++;
         end
      n_total++;
      if (win !== exp_win(5, 7)) $display("FAIL int_win got %h exp %h", win, exp_win(5, 7));
      else n_pass++;
      handshake();
      n_total++;
      if ({busy, win_valid} !== 2'b00) $display("FAIL int_release got %b exp 00", {busy, win_valid});
      else n_pass++;
   endtask

   task automatic test_corners();
      int cyc;
      int exp_lo[4] = '{0, 1, 64, 65};
      int exp_hi[4] = '{4030, 4031, 4094, 4095};
      int zero_lo[5] = '{0, 1, 2, 3, 6};
      int zero_hi[5] = '{2, 5, 6, 7, 8};

      do_fetch(0, 0, cyc);
      n_total++;
      if (cyc !== 10) $display("FAIL c00_latency got %0d exp 10", cyc);
      else n_pass++;
      n_total++;
      if (rd_log.size() !== 4) $display("FAIL c00_nreads got %0d exp 4", rd_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (i < rd_log.size() && rd_log[i] == exp_lo[i]) n_pass++;
         else $display("FAIL c00_read%0d got %0d exp %0d", i, (i < rd_log.size()) ? rd_log[i] : -1, exp_lo[i]);
      end
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (win[zero_lo[i]*8 +: 8] !== 8'd0) $display("FAIL c00_pad%0d got %h exp 00", zero_lo[i], win[zero_lo[i]*8 +: 8]);
         else n_pass++;
      end
      n_total++;
      if (win !== exp_win(0, 0)) $display("FAIL c00_win got %h exp %h", win, exp_win(0, 0));
      else n_pass++;
      handshake();

      do_fetch(63, 63, cyc);
      n_total++;
      if (rd_log.size() !== 4) $display("FAIL c63_nreads got %0d exp 4", rd_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (i < rd_log.size() && rd_log[i] == exp_hi[i]) n_pass++;
         else $display("FAIL c63_read%0d got %0d exp %0d", i, (i < rd_log.size()) ? rd_log[i] : -1, exp_hi[i]);
      end
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (win[zero_hi[i]*8 +: 8] !== 8'd0) $display("FAIL c63_pad%0d got %h exp 00", zero_hi[i], win[zero_hi[i]*8 +: 8]);
         else n_pass++;
      end
      n_total++;
      if (win !== exp_win(63, 63)) $display("FAIL c63_win got %h exp %h", win, exp_win(63, 63));
      else n_pass++;
      handshake();
   endtask

   task automatic test_stall();
      int cyc;
      stall_addr_log.delete();
      stall_read_log.delete();
      stall_addr = 4 * (5 * 64 + 7);
      stall_left = 3;
      do_fetch(5, 7, cyc);
      n_total++;
      if (cyc !== 13) $display("FAIL stall_latency got %0d exp 13", cyc);
      else n_pass++;
      n_total++;
      if (stall_addr_log.size() !== 3) $display("FAIL stall_cycles got %0d exp 3", stall_addr_log.size());
      else n_pass++;
      for (int i = 0; i < stall_addr_log.size(); i++) begin
         n_total++;
         if (stall_addr_log[i] !== 4 * (5 * 64 + 7) || stall_read_log[i] !== 1'b1)
            $display("FAIL stall_hold%0d got addr %0d read %b exp addr %0d read 1",
                     i, stall_addr_log[i], stall_read_log[i], 4 * (5 * 64 + 7));
         else n_pass++;
      end
      n_total++;
      if (win[4*8 +: 8] !== pix(5 * 64 + 7)) $display("FAIL stall_tap4 got %h exp %h", win[4*8 +: 8], pix(5 * 64 + 7));
      else n_pass++;
      n_total++;
      if (win !== exp_win(5, 7)) $display("FAIL stall_win got %h exp %h", win, exp_win(5, 7));
      else n_pass++;
      handshake();
   endtask

   task automatic test_hold();
      int cyc, n0;
      do_fetch(10, 20, cyc);
      n0 = rd_log.size();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            row_in = 6'd30;
            col_in = 6'd40;
            start  = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n_total++;
         if (win_valid !== 1'b1 || win !== exp_win(10, 20))
            $display("FAIL hold_stable%0d got valid %b win %h exp valid 1 win %h", i, win_valid, win, exp_win(10, 20));
         else n_pass++;
      end
      n_total++;
      if (rd_log.size() !== n0 || avm_read !== 1'b0) $display("FAIL hold_noread got %0d reads read %b exp %0d reads read 0", rd_log.size(), avm_read, n0);
      else n_pass++;
      // Start raised in the handshake cycle must be ignored.
      row_in = 6'd30;
      col_in = 6'd40;
      start  = 1'b1;
      win_ready = 1'b1;
      @(posedge clk); #1;
      win_ready = 1'b0;
      n_total++;
      if ({busy, win_valid} !== 2'b00) $display("FAIL hold_release got %b exp 00", {busy, win_valid});
      else n_pass++;
      rd_log.delete();
      @(posedge clk); #1;
      start = 1'b0;
      n_total++;
      if (busy !== 1'b1) $display("FAIL hold_reaccept got %b exp 1", busy);
      else n_pass++;
      cyc = 2;
      while (!win_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_total++;
      if (win_valid !== 1'b1 || win !== exp_win(30, 40)) $display("FAIL hold_next_win got %h exp %h", win, exp_win(30, 40));
      else n_pass++;
      handshake();
   endtask

   task automatic test_reset_mid();
      int cyc, guard;
      stall_addr = 4 * (5 * 64 + 6);
      stall_left = 100;
      row_in = 6'd5;
      col_in = 6'd7;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      guard  = 0;
      while (!waitreq && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      n_total++;
      if (waitreq !== 1'b1 || avm_read !== 1'b1) $display("FAIL rstmid_stall got wait %b read %b exp 1 1", waitreq, avm_read);
      else n_pass++;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (avm_read !== 1'b0 || avm_address !== 32'd0) $display("FAIL rstmid_async got read %b addr %0h exp 0 0", avm_read, avm_address);
      else n_pass++;
      n_total++;
      if ({busy, win_valid} !== 2'b00 || win !== 72'd0) $display("FAIL rstmid_state got %b win %h exp 00 win 0", {busy, win_valid}, win);
      else n_pass++;
      stall_left = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_fetch(5, 7, cyc);
      n_total++;
      if (cyc !== 10 || rd_log.size() !== 9) $display("FAIL rstmid_refetch got %0d cycles %0d reads exp 10 9", cyc, rd_log.size());
      else n_pass++;
      n_total++;
      if (win !== exp_win(5, 7)) $display("FAIL rstmid_win got %h exp %h", win, exp_win(5, 7));
      else n_pass++;
      handshake();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      row_in     = '0;
      col_in     = '0;
      win_ready  = 1'b0;
      waitreq    = 1'b0;
      stall_addr = -1;
      stall_left = 0;
      stalling   = 1'b0;
      test_reset();
      test_interior();
      test_corners();
      test_stall();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
